// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one single-ported memory.
// Data wins by default; a streak limit lets a waiting fetch through.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a requester raises req with stable address/data and holds it
  // until its done pulse; inputs are sampled only at the grant edge, and done
  // always pulses once per grant even if req drops early.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_M1  = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] MAX_STK = 4'(MAX_D_STREAK);

  state_t     r_state;
  state_t     w_next;
  logic       r_owner_d;
  logic       r_we;
  logic [3:0] r_lat;
  logic [3:0] r_streak;
  logic       w_grant_d;
  logic       w_grant_i;
  logic       w_capture;

  always_comb begin
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    if (r_state == S_IDLE) begin
      if (d_req && !(i_req && (r_streak == MAX_STK))) w_grant_d = 1'b1;
      else if (i_req)                                  w_grant_i = 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant_d || w_grant_i) w_next = S_ACCESS;
      S_ACCESS: w_next = (r_we || (LAT_M1 == 4'd0)) ? S_RESP : S_WAIT;
      S_WAIT:   if (r_lat == 4'd1) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Read data is latched on the edge that enters RESP.
  assign w_capture   = (w_next == S_RESP) && (r_state != S_RESP) && !r_we;
  assign mem_en      = (r_state == S_ACCESS);
  assign mem_we      = mem_en && r_we;
  assign i_done      = (r_state == S_RESP) && !r_owner_d;
  assign d_done      = (r_state == S_RESP) && r_owner_d;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_lat     <= 4'd0;
      r_streak  <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_d || w_grant_i) begin
        r_owner_d <= w_grant_d;
        r_we      <= w_grant_d && d_we;
        mem_addr  <= w_grant_d ? d_addr : i_addr;
        mem_wdata <= w_grant_d ? d_wdata : '0;
      end
      if (r_state == S_ACCESS)    r_lat <= LAT_M1;
      else if (r_state == S_WAIT) r_lat <= r_lat - 4'd1;
      // The streak only counts data grants that overtook a waiting fetch.
      if (!i_req)                                   r_streak <= 4'd0;
      else if (w_grant_i)                           r_streak <= 4'd0;
      else if (w_grant_d && (r_streak != 4'd15))    r_streak <= r_streak + 4'd1;
      if (w_capture) begin
        if (r_owner_d) d_rdata <= mem_rdata;
        else           i_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at latency 1, one at
// latency 3, sharing clock and reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cyc = 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // instance A: MEM_LATENCY=1
  logic        a_i_req, a_i_done, a_d_req, a_d_we, a_d_done, a_mem_en, a_mem_we;
  logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [1:0]  a_dbg;
  // instance B: MEM_LATENCY=3
  logic        b_i_req, b_i_done, b_d_req, b_d_we, b_d_done, b_mem_en, b_mem_we;
  logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_dbg;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr == 32'h100) ? 32'hE3A0_0005 : {addr[15:0], 16'hBEEF};
  endfunction

  assign a_mem_rdata = mem_word(a_mem_addr);
  // changes every cycle, so a capture on the wrong edge yields a wrong word
  assign b_mem_rdata = 32'hC0DE_0000 + cyc;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MAX_D_STREAK(4)) u_dut_a (
    .clk(clk), .reset(rst_n),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_done(a_i_done), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_done(a_d_done), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .o_dbg_state(a_dbg)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .MAX_D_STREAK(4)) u_dut_b (
    .clk(clk), .reset(rst_n),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_done(b_i_done), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_done(b_d_done), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .o_dbg_state(b_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_q[$];
  logic act_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    int pulses;
    {a_i_req, a_d_req, a_d_we, b_i_req, b_d_req, b_d_we} = '0;
    {a_i_addr, a_d_addr, a_d_wdata, b_i_addr, b_d_addr, b_d_wdata} = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_en",  a_mem_en, 0);
    chk("rst_mem_we",  a_mem_we, 0);
    chk("rst_mem_adr", a_mem_addr, 0);
    chk("rst_mem_wd",  a_mem_wdata, 0);
    chk("rst_dones",   {a_i_done, a_d_done, b_i_done, b_d_done}, 0);
    chk("rst_rdata",   {a_i_rdata, a_d_rdata}, 0);
    chk("rst_state",   b_dbg, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // single fetch, latency 1
    a_i_req = 1'b1; a_i_addr = 32'h100;
    tick;
    chk("f_mem_en",  a_mem_en, 1);
    chk("f_mem_we",  a_mem_we, 0);
    chk("f_addr",    a_mem_addr, 32'h100);
    chk("f_early",   a_i_done, 0);
    tick;
    chk("f_done",    a_i_done, 1);
    chk("f_rdata",   a_i_rdata, 32'hE3A0_0005);
    chk("f_mem_off", a_mem_en, 0);
    a_i_req = 1'b0;
    tick;
    chk("f_pulse",   a_i_done, 0);
    chk("f_hold",    a_i_rdata, 32'hE3A0_0005);

    // data write
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h64; a_d_wdata = 32'h7;
    tick;
    chk("w_en_we",   {a_mem_en, a_mem_we}, 2'b11);
    chk("w_addr",    a_mem_addr, 32'h64);
    chk("w_wdata",   a_mem_wdata, 32'h7);
    tick;
    chk("w_done",    {a_d_done, a_i_done}, 2'b10);
    chk("w_rd_keep", a_d_rdata, 0);
    a_d_req = 1'b0; a_d_we = 1'b0;
    tick;
    chk("w_pulse",   a_d_done, 0);

    // simultaneous requests: data first, then fetch
    a_i_req = 1'b1; a_i_addr = 32'h200;
    a_d_req = 1'b1; a_d_addr = 32'h300;
    tick;
    chk("b_first",   a_mem_addr, 32'h300);
    tick;
    chk("b_d_done",  {a_d_done, a_i_done}, 2'b10);
    chk("b_d_rdata", a_d_rdata, 32'h0300_BEEF);
    a_d_req = 1'b0;
    tick;
    chk("b_gap",     {a_mem_en, a_d_done, a_i_done}, 3'b000);
    tick;
    chk("b_second",  {a_mem_en, a_mem_addr}, {1'b1, 32'h200});
    tick;
    chk("b_i_done",  {a_d_done, a_i_done}, 2'b01);
    chk("b_i_rdata", a_i_rdata, 32'h0200_BEEF);
    a_i_req = 1'b0;
    tick;

    // streak limit: both held, grants D,D,D,D,I repeating
    for (int i = 0; i < 10; i++) exp_q.push_back((i % 5) != 4);
    a_i_req = 1'b1; a_d_req = 1'b1;
    for (int c = 0; c < 100 && act_q.size() < 10; c++) begin
      tick;
      chk("s_excl", a_i_done & a_d_done, 0);
      if (a_mem_en) act_q.push_back(a_mem_addr == 32'h300);
    end
    // drop both mid-transaction; the granted fetch still completes
    a_i_req = 1'b0; a_d_req = 1'b0;
    chk("s_count", act_q.size(), 10);
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk($sformatf("s_grant%0d", i), act_q[i], exp_q[i]);
    tick;
    chk("s_drop_done", {a_d_done, a_i_done}, 2'b01);
    tick; tick;
    chk("s_idle", a_mem_en, 0);

    // latency-3 read
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h40;
    tick;
    g = cyc;
    chk("l_access", {b_mem_en, b_dbg}, {1'b1, 2'd1});
    tick;
    chk("l_wait",   {b_mem_en, b_dbg, b_d_done}, {1'b0, 2'd2, 1'b0});
    tick;
    chk("l_early",  b_d_done, 0);
    tick;
    chk("l_done",   {b_d_done, b_i_done}, 2'b10);
    chk("l_rdata",  b_d_rdata, 32'hC0DE_0000 + g + 32'd2);
    b_d_req = 1'b0;
    tick;
    chk("l_hold",   b_d_rdata, 32'hC0DE_0000 + g + 32'd2);

    // reset asserted during WAIT
    b_d_req = 1'b1; b_d_addr = 32'h44;
    tick;
    tick;
    chk("r_in_wait", b_dbg, 2'd2);
    b_d_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("r_async",  {b_mem_en, b_i_done, b_d_done, b_dbg}, 5'b0);
    tick;
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      pulses += int'(b_d_done | b_i_done | b_mem_en);
    end
    chk("r_no_done", pulses, 0);
    b_i_req = 1'b1; b_i_addr = 32'h80;
    tick;
    g = cyc;
    chk("r_new_en", {b_mem_en, b_mem_addr}, {1'b1, 32'h80});
    tick; tick;
    chk("r_new_early", b_i_done, 0);
    tick;
    chk("r_new_done",  {b_d_done, b_i_done}, 2'b01);
    chk("r_new_rdata", b_i_rdata, 32'hC0DE_0000 + g + 32'd2);
    b_i_req = 1'b0;
    tick;
    chk("r_new_pulse", b_i_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
